// File: rtl/tx_fifo_serializer.sv
// tx_fifo_serializer: 16x32 write FIFO draining into an LSB-first serial transmitter
module tx_fifo_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_fifo_en,
  input  logic [31:0] in_fifo,
  output logic        tx,
  output logic        full,
  output logic        empty,
  output logic [4:0]  level,
  output logic        busy,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [31:0] mem_q [16];
  logic [4:0]  wp_q, wp_d, rp_q, rp_d, bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [31:0] shift_q, shift_d;
  logic        tx_q, tx_d, overflow_q, overflow_d;
  logic        wr, pop, baud_end;
  assign level    = wp_q - rp_q;
  assign empty    = wp_q == rp_q;
  assign full     = level == 5'd16;
  assign busy     = state_q != IDLE;
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign baud_end = baud_q == 16'(CLKS_PER_BIT - 1);
  assign wr       = write_fifo_en && !full;
  assign pop      = !empty && (state_q == IDLE || (state_q == STOP && baud_end));
  // next-state: pointer updates, pop into the shifter, bit timing through START/DATA/STOP
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    wp_d       = wp_q + {4'd0, wr};
    rp_d       = rp_q + {4'd0, pop};
    overflow_d = write_fifo_en && full;
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      shift_d = mem_q[rp_q[3:0]];
      tx_d    = 1'b0;
    end else if (state_q != IDLE && !baud_end) begin
      baud_d = baud_q + 16'd1;
    end else if (state_q == START) begin
      state_d = DATA;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = shift_q[0];
    end else if (state_q == DATA && bit_q != 5'd31) begin
      baud_d  = '0;
      bit_d   = bit_q + 5'd1;
      shift_d = shift_q >> 1;
      tx_d    = shift_q[1];
    end else if (state_q == DATA) begin
      state_d = STOP;
      baud_d  = '0;
      tx_d    = 1'b1;
    end else if (state_q == STOP) begin
      state_d = IDLE;
      baud_d  = '0;
      tx_d    = 1'b1;
    end
  end
  // state, storage and registered outputs; reset clears everything and forces the line idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      if (wr) mem_q[wp_q[3:0]] <= in_fifo;
    end
  end
endmodule

// File: doc/tx_fifo_serializer.md
TX_FIFO_SERIALIZER -- requirements
Module: tx_fifo_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 write_fifo_en  input  1  bus write strobe; one word offered per asserted cycle.
REQ-005 in_fifo  input  32  bus write data, sampled when write_fifo_en=1.
REQ-006 tx  output  1  serial line, registered, idle high.
REQ-007 full  output  1  FIFO holds 16 words, combinational from pointers.
REQ-008 empty  output  1  FIFO holds 0 words, combinational from pointers.
REQ-009 level  output  5  words stored, wp-rp modulo 32, range 0..16.
REQ-010 busy  output  1  serializer state != IDLE.
REQ-011 overflow  output  1  registered one-cycle pulse on a dropped write.

Function
REQ-012 Storage: 16 x 32-bit memory; 5-bit write pointer wp and read pointer rp; address = pointer[3:0]; pointers wrap 31->0.
REQ-013 Write is accepted iff write_fifo_en=1 and full=0 at that edge: mem[wp[3:0]]<=in_fifo, wp<=wp+1.
REQ-014 Write with full=1: data dropped, wp unchanged, overflow=1 for the following cycle only; a pop in the same cycle does not rescue the write.
REQ-015 Pop: in IDLE with empty=0, or on the last cycle of STOP with empty=0: shift register<=mem[rp[3:0]], rp<=rp+1, state<=START, tx<=0.
REQ-016 Simultaneous accepted write and pop: both take effect; level unchanged.
REQ-017 A pop never occurs while empty=1; a write into an empty FIFO is not bypassed to the serializer in the same cycle.
REQ-018 States: IDLE, START, DATA, STOP; baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state; bit counter 0..31 in DATA.
REQ-019 IDLE: tx=1; exit to START per REQ-015 only.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA with tx=shift[0], bit counter=0.
REQ-021 DATA: each bit held CLKS_PER_BIT cycles, LSB first; at end of each bit, shift right by 1 and bit counter +1; after bit 31, STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; then pop and START if empty=0, else IDLE.
REQ-023 Frame = 1 start + 32 data + 1 stop = 34*CLKS_PER_BIT cycles; back-to-back frames have no idle gap.
REQ-024 Latency: a write accepted at edge N into an empty FIFO with IDLE serializer pops at edge N+1; tx falls after edge N+1.
REQ-025 Writes are accepted during any serializer state; the serializer never stalls the bus except via full.

Reset
REQ-026 Reset low, regardless of clk: wp=0, rp=0, all memory words=0, state=IDLE, counters=0, shift register=0, tx=1, overflow=0.
REQ-027 After reset: empty=1, full=0, level=0, busy=0.
REQ-028 Reset mid-frame aborts the frame: tx returns to 1 immediately; queued words are discarded; no partial frame resumes after release.
REQ-029 First write is accepted at the first rising edge after reset is released.

Verification (CLKS_PER_BIT=4)
REQ-030 Single word: write 0x0000_0001 when idle -> tx=0 for 4 cycles, then 1 for 4 cycles, then 0 for 124 cycles, then 1 (stop); busy high 136 cycles; empty=1 after the pop.
REQ-031 Pattern: write 0xA5A5_0F0F -> data bits observed in order 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, each held 4 cycles.
REQ-032 Overflow: 18 writes on consecutive cycles from idle -> first word popped one cycle after its write; level reaches 16 after the 17th write; 18th write dropped with a 1-cycle overflow pulse; words 1..17 transmitted in order.
REQ-033 Back-to-back: 3 words queued -> 3 frames with no idle gap, 408 cycles total; busy falls and empty=1 afterward.
REQ-034 Wrap: 40 writes with interleaved drain, never more than 16 queued -> pointers wrap past 31; transmitted sequence equals written sequence; no overflow.
REQ-035 Reset mid-DATA: assert reset at bit 10 of a frame with 5 words queued -> tx=1 asynchronously; after release, level=0, busy=0, tx=1; no frame starts.
